// File: rtl/branch_resolver_pkg.sv
// Shared types and constants for the execute-stage branch resolver:
// op_class codes, funct3 branch codes, redirect flag values and FSM states.
package branch_resolver_pkg;

   localparam int INST_ADDR_W = 32;

   typedef enum logic [1:0] {
      OP_NONE = 2'b00,
      OP_COND = 2'b01,
      OP_JAL  = 2'b10,
      OP_JALR = 2'b11
   } op_class_e;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic BRANCH     = 1'b1;
   localparam logic NOT_BRANCH = 1'b0;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'b00,
      ST_REDIRECT = 2'b01,
      ST_SQUASH   = 2'b10
   } res_state_e;

   // JALR targets are forced halfword-aligned by clearing bit 0.
   function automatic logic [INST_ADDR_W-1:0] align_jalr(input logic [INST_ADDR_W-1:0] addr);
      return addr & ~32'h0000_0001;
   endfunction

endpackage

// File: rtl/branch_resolver_if.sv
// Redirect bus from the branch resolver (master) to the PC register / BTB / IF-ID (slave).
interface branch_resolver_if;
   import branch_resolver_pkg::*;

   logic                   branch_flag_out;
   logic [INST_ADDR_W-1:0] branch_target_addr_out;
   logic [INST_ADDR_W-1:0] branch_pc_out;
   logic                   branch_taken_out;
   logic                   squash_out;

   modport master (
      output branch_flag_out,
      output branch_target_addr_out,
      output branch_pc_out,
      output branch_taken_out,
      output squash_out
   );

   modport slave (
      input branch_flag_out,
      input branch_target_addr_out,
      input branch_pc_out,
      input branch_taken_out,
      input squash_out
   );
endinterface

// File: rtl/branch_resolver_cmp.sv
// branch_cmp: combinational condition evaluation and correct next-PC computation
// for one control-flow instruction.
module branch_cmp
   import branch_resolver_pkg::*;
(
   input  logic [1:0]             op_class_in,
   input  logic [2:0]             funct3_in,
   input  logic [INST_ADDR_W-1:0] pc_in,
   input  logic [INST_ADDR_W-1:0] rs1_in,
   input  logic [INST_ADDR_W-1:0] rs2_in,
   input  logic [INST_ADDR_W-1:0] imm_in,
   output logic                   taken_s,
   output logic [INST_ADDR_W-1:0] npc_s
);

   // Actual direction, then the matching next PC.
   always_comb begin
      taken_s = 1'b0;
      npc_s   = pc_in + 32'd4;
      case (op_class_in)
         OP_COND: begin
            case (funct3_in)
               F3_BEQ:  taken_s = (rs1_in == rs2_in);
               F3_BNE:  taken_s = (rs1_in != rs2_in);
               F3_BLT:  taken_s = ($signed(rs1_in) <  $signed(rs2_in));
               F3_BGE:  taken_s = ($signed(rs1_in) >= $signed(rs2_in));
               F3_BLTU: taken_s = (rs1_in <  rs2_in);
               F3_BGEU: taken_s = (rs1_in >= rs2_in);
               default: taken_s = 1'b0;
            endcase
         end
         OP_JAL:  taken_s = 1'b1;
         OP_JALR: taken_s = 1'b1;
         default: taken_s = 1'b0;
      endcase

      if (op_class_in == OP_JALR) begin
         npc_s = align_jalr(rs1_in + imm_in);
      end else if (taken_s) begin
         npc_s = pc_in + imm_in;
      end else begin
         npc_s = pc_in + 32'd4;
      end
   end

endmodule

// File: rtl/branch_resolver.sv
// Execute-stage branch resolver: on mispredict issues a one-cycle redirect, then squashes
// wrong-path instructions for SQUASH_CYCLES. Optional statistics under BRANCH_STATS_EN.
module branch_resolver
   import branch_resolver_pkg::*;
#(
   parameter int SQUASH_CYCLES = 2
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic                   rdy_in,
   input  logic [5:0]             stall,
   input  logic                   valid_in,
   input  logic [1:0]             op_class_in,
   input  logic [2:0]             funct3_in,
   input  logic [INST_ADDR_W-1:0] pc_in,
   input  logic [INST_ADDR_W-1:0] rs1_in,
   input  logic [INST_ADDR_W-1:0] rs2_in,
   input  logic [INST_ADDR_W-1:0] imm_in,
   input  logic [INST_ADDR_W-1:0] pred_npc_in,
   input  logic                   pred_taken_in,
`ifdef BRANCH_STATS_EN
   output logic [31:0]            branch_cnt_out,
   output logic [31:0]            mispredict_cnt_out,
`endif
   branch_resolver_if.master      redir
);

   res_state_e             state_r;
   logic [2:0]             cnt_r;
   logic                   flag_r;
   logic [INST_ADDR_W-1:0] target_r;
   logic [INST_ADDR_W-1:0] bpc_r;
   logic                   taken_r;
   logic                   squash_r;

   logic                   taken_s;
   logic [INST_ADDR_W-1:0] npc_s;
   logic                   accept_s;
   logic                   mispredict_s;

   branch_cmp u_cmp (
      .op_class_in (op_class_in),
      .funct3_in   (funct3_in),
      .pc_in       (pc_in),
      .rs1_in      (rs1_in),
      .rs2_in      (rs2_in),
      .imm_in      (imm_in),
      .taken_s     (taken_s),
      .npc_s       (npc_s)
   );

   // Only IDLE accepts; anything seen during REDIRECT/SQUASH is wrong-path.
   assign accept_s     = valid_in && (op_class_in != OP_NONE) && !stall[3] && rdy_in
                         && (state_r == ST_IDLE);
   assign mispredict_s = (npc_s != pred_npc_in) || (taken_s != pred_taken_in);

   // Redirect FSM, squash counter and registered redirect outputs; rdy_in low freezes all.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_r  <= ST_IDLE;
         cnt_r    <= 3'd0;
         flag_r   <= NOT_BRANCH;
         target_r <= 32'd0;
         bpc_r    <= 32'd0;
         taken_r  <= 1'b0;
         squash_r <= 1'b0;
      end else if (rdy_in) begin
         case (state_r)
            ST_IDLE: begin
               squash_r <= 1'b0;
               if (accept_s && mispredict_s) begin
                  state_r  <= ST_REDIRECT;
                  flag_r   <= BRANCH;
                  target_r <= npc_s;
                  bpc_r    <= pc_in;
                  taken_r  <= taken_s;
               end else begin
                  flag_r   <= NOT_BRANCH;
               end
            end
            ST_REDIRECT: begin
               state_r  <= ST_SQUASH;
               flag_r   <= NOT_BRANCH;
               squash_r <= 1'b1;
               cnt_r    <= 3'(SQUASH_CYCLES);
            end
            ST_SQUASH: begin
               cnt_r <= cnt_r - 3'd1;
               if (cnt_r <= 3'd1) begin
                  state_r  <= ST_IDLE;
                  squash_r <= 1'b0;
               end else begin
                  squash_r <= 1'b1;
               end
            end
            default: begin
               state_r  <= ST_IDLE;
               flag_r   <= NOT_BRANCH;
               squash_r <= 1'b0;
               cnt_r    <= 3'd0;
            end
         endcase
      end
   end

`ifdef BRANCH_STATS_EN
   logic [31:0] branch_cnt_r;
   logic [31:0] mispredict_cnt_r;

   // Accepted-branch and accepted-mispredict counters, wrapping at 2^32.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         branch_cnt_r     <= 32'd0;
         mispredict_cnt_r <= 32'd0;
      end else if (accept_s) begin
         branch_cnt_r <= branch_cnt_r + 32'd1;
         if (mispredict_s) begin
            mispredict_cnt_r <= mispredict_cnt_r + 32'd1;
         end
      end
   end

   assign branch_cnt_out     = branch_cnt_r;
   assign mispredict_cnt_out = mispredict_cnt_r;
`endif

   assign redir.branch_flag_out        = flag_r;
   assign redir.branch_target_addr_out = target_r;
   assign redir.branch_pc_out          = bpc_r;
   assign redir.branch_taken_out       = taken_r;
   assign redir.squash_out             = squash_r;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed testbench for branch_resolver with hand-computed expectations.
// Statistics checks are compiled in only when BRANCH_STATS_EN is defined.
module tb_branch_resolver;
   import branch_resolver_pkg::*;

   logic        clk_in;
   logic        rst_in;
   logic        rdy_in;
   logic [5:0]  stall;
   logic        valid_in;
   logic [1:0]  op_class_in;
   logic [2:0]  funct3_in;
   logic [31:0] pc_in;
   logic [31:0] rs1_in;
   logic [31:0] rs2_in;
   logic [31:0] imm_in;
   logic [31:0] pred_npc_in;
   logic        pred_taken_in;
`ifdef BRANCH_STATS_EN
   logic [31:0] branch_cnt_out;
   logic [31:0] mispredict_cnt_out;
`endif

   int check_cnt;
   int err_cnt;

   branch_resolver_if redir ();

   branch_resolver #(.SQUASH_CYCLES(2)) dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .rdy_in        (rdy_in),
      .stall         (stall),
      .valid_in      (valid_in),
      .op_class_in   (op_class_in),
      .funct3_in     (funct3_in),
      .pc_in         (pc_in),
      .rs1_in        (rs1_in),
      .rs2_in        (rs2_in),
      .imm_in        (imm_in),
      .pred_npc_in   (pred_npc_in),
      .pred_taken_in (pred_taken_in),
`ifdef BRANCH_STATS_EN
      .branch_cnt_out     (branch_cnt_out),
      .mispredict_cnt_out (mispredict_cnt_out),
`endif
      .redir         (redir.master)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      check_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   task automatic set_instr(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] pc,
                            input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                            input logic [31:0] pnpc, input logic pt);
      valid_in      = 1'b1;
      op_class_in   = op;
      funct3_in     = f3;
      pc_in         = pc;
      rs1_in        = a;
      rs2_in        = b;
      imm_in        = imm;
      pred_npc_in   = pnpc;
      pred_taken_in = pt;
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_flag"},   {31'd0, redir.branch_flag_out},  32'd0);
      check_val({tag, "_target"}, redir.branch_target_addr_out,     32'd0);
      check_val({tag, "_pc"},     redir.branch_pc_out,              32'd0);
      check_val({tag, "_taken"},  {31'd0, redir.branch_taken_out}, 32'd0);
      check_val({tag, "_squash"}, {31'd0, redir.squash_out},       32'd0);
   endtask

   initial begin
      check_cnt = 0;
      err_cnt   = 0;
      rst_in = 1'b1; rdy_in = 1'b1; stall = 6'd0;
      set_instr(2'b00, 3'b000, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
      valid_in = 1'b0;
      step(2);
      rst_in = 1'b0;
      check_all_zero("reset");

      // BEQ taken, predicted not taken
      set_instr(2'b01, 3'b000, 32'h100, 32'd5, 32'd5, 32'h20, 32'h104, 1'b0);
      step(1); valid_in = 1'b0;
      check_val("beq_flag",   {31'd0, redir.branch_flag_out},  32'd1);
      check_val("beq_target", redir.branch_target_addr_out,     32'h120);
      check_val("beq_pc",     redir.branch_pc_out,              32'h100);
      check_val("beq_taken",  {31'd0, redir.branch_taken_out}, 32'd1);
      check_val("beq_sq0",    {31'd0, redir.squash_out},       32'd0);
      step(1);
      check_val("beq_flag_off", {31'd0, redir.branch_flag_out}, 32'd0);
      check_val("beq_sq1",    {31'd0, redir.squash_out},       32'd1);
      step(1);
      check_val("beq_sq2",    {31'd0, redir.squash_out},       32'd1);
      step(1);
      check_val("beq_sq_end", {31'd0, redir.squash_out},       32'd0);
      check_val("beq_hold",   redir.branch_target_addr_out,     32'h120);

      // BLT signed: -1 < 1 taken, correctly predicted
      set_instr(2'b01, 3'b100, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h240, 1'b1);
      step(1); valid_in = 1'b0;
      check_val("blt_noflag", {31'd0, redir.branch_flag_out}, 32'd0);
      // BLTU: 0xFFFFFFFF < 1 false -> not taken, mispredicted
      set_instr(2'b01, 3'b110, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h240, 1'b1);
      step(1); valid_in = 1'b0;
      check_val("bltu_flag",   {31'd0, redir.branch_flag_out},  32'd1);
      check_val("bltu_target", redir.branch_target_addr_out,     32'h204);
      check_val("bltu_taken",  {31'd0, redir.branch_taken_out}, 32'd0);
      step(3);

      // JALR clears bit 0
      set_instr(2'b11, 3'b000, 32'h50, 32'h1003, 32'd0, 32'd0, 32'h54, 1'b0);
      step(1); valid_in = 1'b0;
      check_val("jalr_flag",   {31'd0, redir.branch_flag_out},  32'd1);
      check_val("jalr_target", redir.branch_target_addr_out,     32'h1002);
      check_val("jalr_taken",  {31'd0, redir.branch_taken_out}, 32'd1);
      step(3);
      set_instr(2'b10, 3'b000, 32'h300, 32'd0, 32'd0, 32'h10, 32'h310, 1'b1);
      step(1); valid_in = 1'b0;
      check_val("jal_noflag",  {31'd0, redir.branch_flag_out}, 32'd0);
      check_val("jal_hold_pc", redir.branch_pc_out,            32'h50);

      // Unlisted funct3 010: never taken
      set_instr(2'b01, 3'b010, 32'h400, 32'd0, 32'd0, 32'h40, 32'h404, 1'b0);
      step(1);
      check_val("f3x_noflag", {31'd0, redir.branch_flag_out}, 32'd0);
      set_instr(2'b01, 3'b010, 32'h400, 32'd0, 32'd0, 32'h40, 32'h440, 1'b1);
      step(1); valid_in = 1'b0;
      check_val("f3x_target", redir.branch_target_addr_out,     32'h404);
      check_val("f3x_taken",  {31'd0, redir.branch_taken_out}, 32'd0);
      step(3);

      // stall[3] blocks acceptance
      stall = 6'b001000;
      set_instr(2'b01, 3'b000, 32'h480, 32'd1, 32'd2, 32'h80, 32'h488, 1'b0);
      step(1); valid_in = 1'b0; stall = 6'd0;
      check_val("stall_noflag", {31'd0, redir.branch_flag_out}, 32'd0);

      // Back-to-back mispredicts: only 1+SQUASH_CYCLES spacing allowed
      set_instr(2'b01, 3'b000, 32'h500, 32'd1, 32'd2, 32'h80, 32'h508, 1'b0);
      step(1);
      check_val("b2b_first", redir.branch_pc_out, 32'h500);
      set_instr(2'b01, 3'b000, 32'h600, 32'd1, 32'd2, 32'h80, 32'h608, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1);
         check_val($sformatf("b2b_ign%0d", i), {31'd0, redir.branch_flag_out}, 32'd0);
      end
      check_val("b2b_pc_hold", redir.branch_pc_out, 32'h500);
      set_instr(2'b01, 3'b000, 32'h700, 32'd1, 32'd2, 32'h80, 32'h708, 1'b0);
      step(1); valid_in = 1'b0;
      check_val("b2b_second",     {31'd0, redir.branch_flag_out}, 32'd1);
      check_val("b2b_second_pc",  redir.branch_pc_out,            32'h700);
      check_val("b2b_second_tgt", redir.branch_target_addr_out,   32'h704);
      step(3);

      // rdy_in low during REDIRECT stretches the pulse
      set_instr(2'b01, 3'b000, 32'h800, 32'd1, 32'd2, 32'h80, 32'h808, 1'b0);
      step(1); valid_in = 1'b0; rdy_in = 1'b0;
      step(2);
      check_val("rdy_flag_held", {31'd0, redir.branch_flag_out}, 32'd1);
      check_val("rdy_sq_held",   {31'd0, redir.squash_out},      32'd0);
      rdy_in = 1'b1;
      step(1);
      check_val("rdy_flag_off", {31'd0, redir.branch_flag_out}, 32'd0);
      check_val("rdy_sq1",      {31'd0, redir.squash_out},      32'd1);
      step(1);
      check_val("rdy_sq2",      {31'd0, redir.squash_out},      32'd1);
      step(1);
      check_val("rdy_sq_end",   {31'd0, redir.squash_out},      32'd0);

      // Reset during SQUASH
      set_instr(2'b01, 3'b000, 32'h900, 32'd1, 32'd2, 32'h80, 32'h908, 1'b0);
      step(1); valid_in = 1'b0;
      step(1);
      check_val("rst_pre_sq", {31'd0, redir.squash_out}, 32'd1);
      rst_in = 1'b1;
      step(1);
      rst_in = 1'b0;
      check_all_zero("rst_mid");
      step(1);
      check_val("rst_no_pulse", {31'd0, redir.branch_flag_out}, 32'd0);
      check_val("rst_no_sq",    {31'd0, redir.squash_out},      32'd0);

      // Statistics: 10 branches, 3 mispredicted (none during squash)
      rst_in = 1'b1;
      step(1);
      rst_in = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (i == 2 || i == 5 || i == 8) begin
            set_instr(2'b01, 3'b000, 32'h1000 + 32'(i * 16), 32'd0, 32'd0, 32'd8,
                      32'h1004 + 32'(i * 16), 1'b0);
            step(1); valid_in = 1'b0;
            step(3);
         end else begin
            set_instr(2'b01, 3'b000, 32'h1000 + 32'(i * 16), 32'd0, 32'd0, 32'd8,
                      32'h1008 + 32'(i * 16), 1'b1);
            step(1); valid_in = 1'b0;
         end
      end
      check_val("stats_last_pc", redir.branch_pc_out, 32'h1080);
`ifdef BRANCH_STATS_EN
      check_val("stats_branch", branch_cnt_out,     32'd10);
      check_val("stats_misp",   mispredict_cnt_out, 32'd3);
`endif

      $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/branch_resolver.md
# branch_resolver

Execute-stage branch resolution unit: the producing end of the PC/BTB redirect interface. Evaluates each control-flow instruction, compares the correct next PC against the fetch-side prediction, and, on mismatch, issues a one-cycle redirect carrying the BTB update (branch PC, target, taken) to the PC register. It then squashes wrong-path instructions for a fixed number of cycles.

## Interface
Parameters:
- SQUASH_CYCLES, 2, cycles `squash_out` stays high after a redirect (1..7)

Ports:
- clk_in  input  1  clock
- rst_in  input  1  reset; synchronous, active-high
- rdy_in  input  1  global ready; low freezes all state
- stall  input  6  pipeline stall vector; stall[3] holds the execute stage
- valid_in  input  1  instruction present in execute
- op_class_in  input  2  00 none, 01 conditional branch, 10 JAL, 11 JALR
- funct3_in  input  3  branch condition (BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111)
- pc_in  input  32  instruction PC
- rs1_in  input  32  operand 1
- rs2_in  input  32  operand 2
- imm_in  input  32  sign-extended immediate
- pred_npc_in  input  32  next PC fetch actually used after this instruction
- pred_taken_in  input  1  fetch predicted taken (pre_to_take carried down the pipe)
- branch_flag_out  output  1  redirect pulse (`Branch when asserted)
- branch_target_addr_out  output  32  correct next PC
- branch_pc_out  output  32  PC of the resolved instruction
- branch_taken_out  output  1  actual direction
- squash_out  output  1  kill wrong-path instructions in IF/ID

## Operation
- Accept: `valid_in && op_class_in != 00 && stall[3] == NotStop && rdy_in`, while the FSM is in IDLE.
- Actual taken:
  - conditional branch: per funct3; signed compare for BLT/BGE, unsigned for BLTU/BGEU.
  - JAL, JALR: always taken.
  - Unlisted funct3 (010, 011): not taken.
- Correct next PC, all modulo 2^32:
  - taken conditional branch or JAL: pc_in + imm_in.
  - JALR: (rs1_in + imm_in) & ~1.
  - not taken: pc_in + 4.
- Mispredict: correct next PC != pred_npc_in, or taken != pred_taken_in.
- On mispredict, register the outputs and pulse branch_flag_out:
  - target = correct next PC.
  - pc = pc_in.
  - taken = actual direction.
- Correctly predicted instructions produce no output activity.
- FSM:
  - IDLE: on mispredict go to REDIRECT.
  - REDIRECT: branch_flag_out = 1 for this one cycle; load squash counter = SQUASH_CYCLES; go to SQUASH.
  - SQUASH: squash_out = 1; counter decrements each cycle in which rdy_in is high; return to IDLE after the cycle in which the counter reads 1.
- Instructions presented during REDIRECT/SQUASH are wrong-path. They are ignored: no redirect, no statistics.
- rdy_in low: FSM, counter and outputs hold.
- stall[3] high: no new accept. REDIRECT/SQUASH still advance, because the redirect has already been issued.

## Timing
- Reset values: branch_flag_out 0, branch_target_addr_out 0, branch_pc_out 0, branch_taken_out 0, squash_out 0; FSM IDLE; counter 0.
- Latency: mispredict accepted in cycle N gives branch_flag_out = 1 in cycle N+1 only. squash_out is high in cycles N+2 .. N+1+SQUASH_CYCLES.
- The target/pc/taken outputs hold their last values after the pulse.
- At most one redirect per 1+SQUASH_CYCLES cycles.
- A mispredict accepted in the same cycle the FSM returns to IDLE is legal and starts a new REDIRECT next cycle.
- Reset mid-REDIRECT/SQUASH: the next cycle is IDLE with all outputs 0, and no pending pulse survives.

## Configuration
- BRANCH_STATS_EN defined:
  - Adds output ports branch_cnt_out (32) and mispredict_cnt_out (32), reset to 0.
  - branch_cnt_out counts accepted branches; mispredict_cnt_out counts accepted mispredicts.
  - Both wrap at 2^32 and are updated in the accept cycle, visible next cycle.
- Not defined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared defines.v holds the op_class codes, the funct3 branch codes, `Branch/`NotBranch and `InstAddrBus.
- One combinational sub-module, branch_cmp: condition evaluation plus target computation, outputting actual taken and correct next PC.
- FSM, squash counter and output registers live in branch_resolver.

## Test plan
- BEQ pc=0x100, rs1=rs2=5, imm=0x20, pred_npc=0x104, pred_taken=0 -> next cycle flag=1, target=0x120, pc=0x100, taken=1; squash high 2 cycles.
- BLT rs1=0xFFFFFFFF, rs2=1, pc=0x200, imm=0x40, pred_npc=0x240, pred_taken=1 -> no flag. The same operands as BLTU -> flag=1, target=0x204, taken=0.
- JALR rs1=0x1003, imm=0, pc=0x50, pred_npc=0x54 -> flag=1, target=0x1002, taken=1. JAL with pred_npc already correct -> no flag.
- Mispredict, then a second mispredicting branch presented in each of the next 3 cycles -> exactly one flag pulse. A 4th-cycle mispredict -> second pulse.
- Assert rst_in during SQUASH -> next cycle all outputs 0, FSM IDLE. Hold rdy_in low during REDIRECT -> flag pulse extends until rdy_in returns, then SQUASH proceeds.
- With BRANCH_STATS_EN: 10 branches, 3 mispredicted, none during squash -> branch_cnt_out=10, mispredict_cnt_out=3.
